// File: rtl/dds_phase_acc_if.sv
// Control/data bundle for the DDS phase accumulator.
// Sweep ports exist only when DDS_SWEEP_EN is defined.
interface dds_phase_acc_if;
    logic        en;
    logic        upd;
    logic [13:0] state_freq;
    logic [7:0]  state_phase;
    logic        upd_ack;
    logic [15:0] addr;
    logic        addr_vld;
    logic        wrap;
`ifdef DDS_SWEEP_EN
    logic [7:0]  sweep_step;
    logic [13:0] sweep_stop;

    modport master (
        output en, upd, state_freq, state_phase, sweep_step, sweep_stop,
        input  upd_ack, addr, addr_vld, wrap
    );
    modport slave (
        input  en, upd, state_freq, state_phase, sweep_step, sweep_stop,
        output upd_ack, addr, addr_vld, wrap
    );
`else
    modport master (
        output en, upd, state_freq, state_phase,
        input  upd_ack, addr, addr_vld, wrap
    );
    modport slave (
        input  en, upd, state_freq, state_phase,
        output upd_ack, addr, addr_vld, wrap
    );
`endif
endinterface

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with shadowed tuning registers applied at glitch-free points.
// Optional frequency sweep on each wrap is enabled by defining DDS_SWEEP_EN.
module dds_phase_acc (
    input  logic            clk,
    input  logic            rst_n,
    dds_phase_acc_if.slave  bus
);
    typedef enum logic {StIdle, StRun} state_e;

    state_e      state;
    logic [15:0] acc;
    logic [13:0] f_act;
    logic [7:0]  p_act;
    logic [13:0] f_sh;
    logic [7:0]  p_sh;
    logic        pend;

    logic        run_edge;
    logic [16:0] sum;
    logic        carry;
    logic        apply;
    logic        sweep_hit;
    logic [13:0] f_swept;

    always_comb begin
        run_edge = (state == StRun) && bus.en;
        sum      = {1'b0, acc} + {3'b000, f_act};
        carry    = run_edge && sum[16];
        // Shadow is swapped only where the output phase cannot glitch.
        apply    = pend && ((state == StIdle) || (f_act == 14'd0) || carry);
    end

`ifdef DDS_SWEEP_EN
    logic [14:0] f_sum;

    always_comb begin
        f_sum     = {1'b0, f_act} + {7'd0, bus.sweep_step};
        f_swept   = (f_sum > {1'b0, bus.sweep_stop}) ? bus.sweep_stop : f_sum[13:0];
        sweep_hit = carry && !apply && (bus.sweep_step != 8'd0) && (f_act < bus.sweep_stop);
    end
`else
    always_comb begin
        f_swept   = f_act;
        sweep_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            acc          <= 16'd0;
            f_act        <= 14'd0;
            p_act        <= 8'd0;
            f_sh         <= 14'd0;
            p_sh         <= 8'd0;
            pend         <= 1'b0;
            bus.addr     <= 16'd0;
            bus.addr_vld <= 1'b0;
            bus.wrap     <= 1'b0;
            bus.upd_ack  <= 1'b0;
        end else begin
            bus.upd_ack <= apply;

            if (apply) begin
                f_act <= f_sh;
                p_act <= p_sh;
                pend  <= 1'b0;
            end else if (sweep_hit) begin
                f_act <= f_swept;
            end

            // A coincident strobe re-arms pend after the old shadow is applied.
            if (bus.upd) begin
                f_sh <= bus.state_freq;
                p_sh <= bus.state_phase;
                pend <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    acc          <= 16'd0;
                    bus.addr_vld <= 1'b0;
                    bus.wrap     <= 1'b0;
                    if (bus.en) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (bus.en) begin
                        acc          <= sum[15:0];
                        bus.addr     <= acc + {p_act, 8'h00};
                        bus.addr_vld <= 1'b1;
                        bus.wrap     <= sum[16];
                    end else begin
                        state        <= StIdle;
                        acc          <= 16'd0;
                        bus.addr     <= 16'd0;
                        bus.addr_vld <= 1'b0;
                        bus.wrap     <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_phase_acc.sv
// Scoreboard bench for dds_phase_acc; the sweep scenario builds only with DDS_SWEEP_EN.
module tb_dds_phase_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dds_phase_acc_if bus ();

    dds_phase_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        wrap;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Every valid sample must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.addr_vld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sample_unexpected got addr=%h wrap=%b ack=%b want none",
                             bus.addr, bus.wrap, bus.upd_ack);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.addr, bus.wrap, bus.upd_ack} !== e) begin
                        bad++;
                        $display("FAIL sample got addr=%h wrap=%b ack=%b want addr=%h wrap=%b ack=%b",
                                 bus.addr, bus.wrap, bus.upd_ack, e.addr, e.wrap, e.ack);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [13:0] f, input logic [7:0] p);
        bus.upd = 1'b1;
        bus.state_freq = f;
        bus.state_phase = p;
        tick();
        bus.upd = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic w, input logic k);
        exp_t e;
        e.addr = a;
        e.wrap = w;
        e.ack  = k;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({bus.addr, bus.addr_vld, bus.wrap, bus.upd_ack} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0",
                     {bus.addr, bus.addr_vld, bus.wrap, bus.upd_ack});
        end
        bus.en = 1'b1;
        tick();
        tick();
        total++;
        if (bus.addr_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_vld got %b want 0", bus.addr_vld);
        end
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if ({bus.addr_vld, bus.upd_ack} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset got %b want 00", {bus.addr_vld, bus.upd_ack});
        end
    endtask

    task automatic test_basic();
        load(14'h0100, 8'h00);
        total++;
        if (bus.upd_ack !== 1'b0) begin
            bad++;
            $display("FAIL basic_no_early_ack got %b want 0", bus.upd_ack);
        end
        bus.en = 1'b1;
        tick();
        total++;
        if ({bus.upd_ack, bus.addr_vld} !== 2'b10) begin
            bad++;
            $display("FAIL basic_ack got ack,vld=%b want 10", {bus.upd_ack, bus.addr_vld});
        end
        for (int k = 0; k < 600; k++) begin
            push(16'(k * 256), (k % 256) == 255, 1'b0);
        end
        repeat (600) tick();
        bus.en = 1'b0;
        tick();
        total++;
        if ({bus.addr, bus.addr_vld, bus.wrap} !== 18'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_stop got addr=%h vld=%b left=%0d want 0 0 0",
                     bus.addr, bus.addr_vld, exp_q.size());
        end
    endtask

    task automatic test_phase();
        load(14'h0100, 8'h40);
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.upd_ack !== 1'b1) begin
            bad++;
            $display("FAIL phase_ack got %b want 1", bus.upd_ack);
        end
        for (int k = 0; k < 300; k++) begin
            push(16'(16'h4000 + k * 256), (k % 256) == 255, 1'b0);
        end
        repeat (300) tick();
        bus.en = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL phase_drain got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_freq_change();
        load(14'h0100, 8'h00);
        bus.en = 1'b1;
        tick();
        for (int k = 0; k < 280; k++) begin
            if (k < 256) push(16'(k * 256), k == 255, k == 255);
            else         push(16'((k - 256) * 16'h2000), ((k - 256) % 8) == 7, 1'b0);
        end
        for (int k = 0; k < 280; k++) begin
            if (k == 10) begin
                bus.upd = 1'b1;
                bus.state_freq = 14'h2000;
                bus.state_phase = 8'h00;
            end
            tick();
            bus.upd = 1'b0;
        end
        bus.en = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL freq_change_drain got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_zero_freq();
        load(14'h0000, 8'h12);
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.upd_ack !== 1'b1) begin
            bad++;
            $display("FAIL zero_first_ack got %b want 1", bus.upd_ack);
        end
        for (int k = 0; k < 20; k++) begin
            if (k <= 6) push(16'h1200, 1'b0, k == 6);
            else        push(16'(16'h1200 + (k - 7) * 16), 1'b0, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                bus.upd = 1'b1;
                bus.state_freq = 14'h0010;
                bus.state_phase = 8'h12;
            end
            tick();
            bus.upd = 1'b0;
        end
        bus.en = 1'b0;
        tick();
        total++;
        if ({bus.addr, bus.addr_vld, bus.wrap} !== 18'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL zero_stop got addr=%h vld=%b left=%0d want 0 0 0",
                     bus.addr, bus.addr_vld, exp_q.size());
        end
    endtask

    task automatic test_stop_restart();
        int acks;
        bus.en = 1'b1;
        tick();
        total++;
        if ({bus.addr_vld, bus.upd_ack} !== 2'b00) begin
            bad++;
            $display("FAIL restart_first_edge got %b want 00", {bus.addr_vld, bus.upd_ack});
        end
        for (int k = 0; k < 5; k++) push(16'(16'h1200 + k * 16), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                bus.upd = 1'b1;
                bus.state_freq = 14'h0020;
                bus.state_phase = 8'h00;
            end
            tick();
            bus.upd = 1'b0;
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.en = 1'b0;
        #1;
        total++;
        if ({bus.addr, bus.addr_vld, bus.wrap, bus.upd_ack} !== 19'd0 || dut.pend !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got %h pend=%b want 0 0",
                     {bus.addr, bus.addr_vld, bus.wrap, bus.upd_ack}, dut.pend);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL restart_drain got %0d left want 0", exp_q.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (10) begin
            tick();
            if (bus.upd_ack === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL discarded_pend got %0d acks want 0", acks);
        end
        for (int k = 0; k < 3; k++) push(16'h0000, 1'b0, 1'b0);
        bus.en = 1'b1;
        tick();
        repeat (3) tick();
        bus.en = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL post_reset_drain got %0d left want 0", exp_q.size());
        end
    endtask

`ifdef DDS_SWEEP_EN
    task automatic test_sweep();
        logic [15:0] acc_m;
        logic [16:0] s;
        logic [14:0] f_m;
        bus.sweep_step = 8'h80;
        bus.sweep_stop = 14'h1100;
        load(14'h1000, 8'h00);
        bus.en = 1'b1;
        tick();
        acc_m = 16'd0;
        f_m = 15'h1000;
        for (int k = 0; k < 60; k++) begin
            s = {1'b0, acc_m} + {2'b00, f_m};
            push(acc_m, s[16], 1'b0);
            acc_m = s[15:0];
            if (s[16] && f_m < 15'h1100) f_m = (f_m + 15'h80 > 15'h1100) ? 15'h1100 : f_m + 15'h80;
        end
        repeat (60) tick();
        bus.en = 1'b0;
        tick();
        total++;
        if (dut.f_act !== 14'h1100 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL sweep_final got f_act=%h left=%0d want 1100 0", dut.f_act, exp_q.size());
        end
        bus.sweep_step = 8'h00;
    endtask
`endif

    initial begin
        bus.en = 1'b0;
        bus.upd = 1'b0;
        bus.state_freq = 14'd0;
        bus.state_phase = 8'd0;
`ifdef DDS_SWEEP_EN
        bus.sweep_step = 8'd0;
        bus.sweep_stop = 14'd0;
`endif
        test_reset();
        test_basic();
        test_phase();
        test_freq_change();
        test_zero_freq();
        test_stop_restart();
`ifdef DDS_SWEEP_EN
        test_sweep();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dds_phase_acc.md
DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: en  input  1  run enable; 1 = RUN, 0 = IDLE.
REQ-004 SHALL have port: upd  input  1  parameter load strobe, one cycle per request.
REQ-005 SHALL have port: state_freq  input  14  frequency tuning word, sampled only when upd=1.
REQ-006 SHALL have port: state_phase  input  8  phase offset, sampled only when upd=1.
REQ-007 SHALL have port: upd_ack  output  1  one-cycle pulse when shadow values become active.
REQ-008 SHALL have port: addr  output  16  phase address to the sine table stage.
REQ-009 SHALL have port: addr_vld  output  1  addr is valid.
REQ-010 SHALL have port: wrap  output  1  one-cycle pulse on accumulator overflow.

Function
REQ-011 SHALL hold registers acc[15:0], f_act[13:0], p_act[7:0], shadow f_sh[13:0] and p_sh[7:0], pend flag, and state IDLE/RUN.
REQ-012 SHALL move IDLE->RUN on an edge with en=1, and RUN->IDLE on an edge with en=0. On RUN->IDLE: acc<=0, addr<=0, addr_vld<=0, wrap<=0.
REQ-013 SHALL, on each RUN edge: acc<=acc+{2'b00,f_act} mod 2^16; addr<=acc+{p_act,8'h00} mod 2^16, using the pre-increment acc; addr_vld<=1.
REQ-014 SHALL hold acc=0 and addr_vld=0 in IDLE. First valid addr = {p_act,8'h00}, one edge after entering RUN.
REQ-015 SHALL set wrap<=1 on a RUN edge where the 16-bit add in REQ-013 carries out, and wrap<=0 otherwise.
REQ-016 SHALL, on an edge with upd=1, capture f_sh<=state_freq, p_sh<=state_phase and set pend<=1. A new upd while pend=1 overwrites the shadow (latest wins).
REQ-017 SHALL apply the shadow (f_act<=f_sh, p_act<=p_sh, pend<=0, upd_ack<=1) on the first edge with pend=1 where any of these holds:
- state is IDLE;
- f_act=0;
- the REQ-013 add carries out (same edge wrap is set).
REQ-018 SHALL use the old f_act/p_act for the increment and addr on the apply edge. New values take effect from the following edge.
REQ-019 SHALL, when upd=1 coincides with an apply edge, apply the previous shadow, capture the new values and leave pend=1.
REQ-020 SHALL drive upd_ack=0 on every edge that is not an apply edge.

Reset
REQ-021 SHALL, while rst_n=0, force immediately:
- state=IDLE; acc, f_act, p_act, f_sh, p_sh = 0; pend=0;
- addr=0, addr_vld=0, wrap=0, upd_ack=0.
REQ-022 SHALL discard any pending update on reset mid-operation. Operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-023 SHALL, with macro DDS_SWEEP_EN defined, add inputs sweep_step[7:0] and sweep_stop[13:0].
- On each wrap edge that is not an apply edge, f_act<=min(f_act+sweep_step, sweep_stop).
- Unchanged when f_act>=sweep_stop or sweep_step=0.
- An apply edge always takes priority over the sweep.
REQ-024 SHALL, without DDS_SWEEP_EN, omit the sweep ports and logic; f_act changes only via REQ-017.

Verification
REQ-025 SHALL check: reset; upd with freq=0x0100, phase=0x00 in IDLE; then en=1 -> upd_ack next edge; addr 0x0000,0x0100,0x0200,...; wrap pulses once every 256 valid samples.
REQ-026 SHALL check: upd with phase=0x40, freq=0x0100, then run -> first addr=0x4000, then 0x4100. Wrap timing is unchanged from REQ-025.
REQ-027 SHALL check: running at freq=0x0100, upd freq=0x2000 at sample 10 -> no change until the wrap edge; upd_ack coincides with wrap; later addr steps are 0x2000.
REQ-028 SHALL check: running at freq=0, upd freq=0x0010 -> upd_ack on the next edge; addr then increments by 0x0010.
REQ-029 SHALL check: en=0 mid-run, then en=1 -> addr_vld=0 and addr=0 after one edge; restart gives first addr={p_act,8'h00}. Also rst_n=0 mid-run with pend=1 -> upd_ack never fires.
REQ-030 SHALL check, with DDS_SWEEP_EN: freq=0x1000, sweep_step=0x80, sweep_stop=0x1100 -> f_act reads 0x1080 then 0x1100 after successive wraps, then holds at 0x1100.
